// File: rtl/dawson_pkg.sv
// Shared definitions for the Dawson strobe/acknowledge protocol blocks.
// Holds the default datapath width and the responder FSM state encoding.
package dawson_pkg;

  localparam int DAWSON_W = 64;

  typedef enum logic [2:0] {
    RESET = 3'd0,
    GET_A = 3'd1,
    GET_B = 3'd2,
    START = 3'd3,
    WAIT  = 3'd4,
    PUT_Z = 3'd5
  } dawson_state_t;

endpackage

// File: rtl/dawson_responder.sv
// Unit-side end of the Dawson protocol: collects A then B, launches a start/done
// compute core, and holds the captured result on output_z until acknowledged.
module dawson_responder
  import dawson_pkg::*;
#(
  parameter int W     = DAWSON_W,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [W-1:0]     input_a,
  input  logic             input_a_stb,
  output logic             input_a_ack,
  input  logic [W-1:0]     input_b,
  input  logic             input_b_stb,
  output logic             input_b_ack,
  output logic [W-1:0]     output_z,
  output logic             output_z_stb,
  input  logic             output_z_ack,
  output logic [W-1:0]     core_a,
  output logic [W-1:0]     core_b,
  output logic             core_start,
  input  logic [W-1:0]     core_result,
  input  logic             core_done,
  output logic [CNT_W-1:0] op_count
);

  dawson_state_t    state;
  dawson_state_t    state_next;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic [W-1:0]     z_reg;
  logic [CNT_W-1:0] count_reg;

  logic accept_a;
  logic accept_b;
  logic capture_z;
  logic deliver_z;

  // Transfers are qualified by the registered state only, so stb never reaches ack.
  assign accept_a  = (state == GET_A) && input_a_stb;
  assign accept_b  = (state == GET_B) && input_b_stb;
  assign capture_z = ((state == START) || (state == WAIT)) && core_done;
  assign deliver_z = (state == PUT_Z) && output_z_ack;

  always_comb begin
    state_next = state;
    unique case (state)
      RESET: state_next = GET_A;
      GET_A: if (input_a_stb) state_next = GET_B;
      GET_B: if (input_b_stb) state_next = START;
      START: state_next = core_done ? PUT_Z : WAIT;
      WAIT:  if (core_done) state_next = PUT_Z;
      PUT_Z: if (output_z_ack) state_next = GET_A;
      default: state_next = RESET;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= RESET;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      z_reg     <= '0;
      count_reg <= '0;
    end else begin
      if (accept_a) begin
        a_reg <= input_a;
      end
      if (accept_b) begin
        b_reg <= input_b;
      end
      if (capture_z) begin
        z_reg <= core_result;
      end
      if (deliver_z) begin
        count_reg <= count_reg + CNT_W'(1);
      end
    end
  end

  assign input_a_ack  = (state == GET_A);
  assign input_b_ack  = (state == GET_B);
  assign core_start   = (state == START);
  assign output_z_stb = (state == PUT_Z);
  assign output_z     = z_reg;
  assign core_a       = a_reg;
  assign core_b       = b_reg;
  assign op_count     = count_reg;

endmodule

// File: tb/tb_dawson_responder.sv
// Scoreboard bench for dawson_responder with an XOR core of programmable latency.
// Accepted operand pairs queue their expected result; delivered results are popped and compared.
module tb_dawson_responder;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [63:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [63:0] input_b;
  logic        input_b_stb;
  logic        input_b_ack;
  logic [63:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;
  logic [63:0] core_a;
  logic [63:0] core_b;
  logic        core_start;
  logic [63:0] core_result;
  logic        core_done;
  logic [15:0] op_count;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          core_lat = 2;
  int          done_count = 0;
  int          a_acc_cyc = 0;
  logic [63:0] pend_a = '0;
  logic [63:0] sb [$];
  logic [7:0]  done_sr = '0;

  dawson_responder #(.W(64), .CNT_W(16)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .input_b      (input_b),
    .input_b_stb  (input_b_stb),
    .input_b_ack  (input_b_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack),
    .core_a       (core_a),
    .core_b       (core_b),
    .core_start   (core_start),
    .core_result  (core_result),
    .core_done    (core_done),
    .op_count     (op_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // XOR core: done follows the start pulse by core_lat cycles (0 means same cycle).
  always @(posedge clock) done_sr <= {done_sr[6:0], core_start};

  always_comb begin
    core_result = core_a ^ core_b;
    core_done   = (core_lat == 0) ? core_start : done_sr[core_lat-1];
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Handshakes seen at the negedge complete on the following posedge.
  always @(negedge clock) begin
    if (reset_n) begin
      if (input_a_stb && input_a_ack) pend_a = input_a;
      if (input_b_stb && input_b_ack) sb.push_back(pend_a ^ input_b);
      if (output_z_stb && output_z_ack) begin
        checkOutput("sb_has_entry", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          checkOutput("output_z", output_z, sb.pop_front());
          checkOutput("op_count_at_z", 64'(op_count), 64'(16'(done_count)));
          done_count++;
        end
      end
    end
  end

  task automatic nextDrive;
    @(posedge clock);
    #1;
  endtask

  task automatic nextSample;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) nextDrive;
  endtask

  task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b);
    bit got;
    nextDrive;
    input_a = a;
    input_b = b;
    input_a_stb = 1'b1;
    input_b_stb = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      nextSample;
      if (input_a_ack) begin
        got = 1'b1;
        a_acc_cyc = cyc;
      end
    end
    checkOutput("a_accept", 64'(got), 64'd1);
    nextDrive;
    input_a_stb = 1'b0;
    nextSample;
    checkOutput("b_accept", 64'(input_b_ack), 64'd1);
    nextDrive;
    input_b_stb = 1'b0;
  endtask

  task automatic waitDrain(input string tag);
    bit drained;
    drained = 1'b0;
    for (int i = 0; i < 30 && !drained; i++) begin
      nextSample;
      #1;
      drained = (sb.size() == 0);
    end
    checkOutput(tag, 64'(drained), 64'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] ra;
    logic [63:0] rb [5];
    bit          seen;
    int          base;

    reset_n      = 1'b0;
    input_a      = '0;
    input_b      = '0;
    input_a_stb  = 1'b0;
    input_b_stb  = 1'b0;
    output_z_ack = 1'b0;

    // Reset state
    repeat (3) nextSample;
    checkOutput("rst_a_ack", 64'(input_a_ack), 64'd0);
    checkOutput("rst_b_ack", 64'(input_b_ack), 64'd0);
    checkOutput("rst_z_stb", 64'(output_z_stb), 64'd0);
    checkOutput("rst_z", output_z, 64'd0);
    checkOutput("rst_start", 64'(core_start), 64'd0);
    checkOutput("rst_core_a", core_a, 64'd0);
    checkOutput("rst_count", 64'(op_count), 64'd0);
    nextDrive;
    reset_n = 1'b1;
    nextSample;
    checkOutput("idle_after_rst", 64'(input_a_ack), 64'd0);
    nextSample;
    checkOutput("get_a_after_idle", 64'(input_a_ack), 64'd1);

    // Basic operation with a 2-cycle core, then 10 cycles of back-pressure
    core_lat = 2;
    applyStimulus(64'h3FF3AE147AE147AE, 64'h40123D70A3D70A3D);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      nextSample;
      seen = output_z_stb;
    end
    checkOutput("z_latency", 64'(cyc - a_acc_cyc), 64'd5);
    for (int i = 0; i < 10; i++) begin
      nextSample;
      checkOutput("bp_z_stb", 64'(output_z_stb), 64'd1);
      checkOutput("bp_z", output_z, 64'h7FE19364D9364D93);
      checkOutput("bp_a_ack", 64'(input_a_ack), 64'd0);
      checkOutput("bp_start", 64'(core_start), 64'd0);
    end
    checkOutput("bp_count", 64'(op_count), 64'd0);
    nextDrive;
    output_z_ack = 1'b1;
    nextDrive;
    output_z_ack = 1'b0;
    nextSample;
    checkOutput("basic_count", 64'(op_count), 64'd1);
    checkOutput("basic_z_stb_low", 64'(output_z_stb), 64'd0);
    checkOutput("basic_back_to_a", 64'(input_a_ack), 64'd1);

    // Ordering: B offered three cycles before A, with B data changing every cycle
    idle(10);
    core_lat = 1;
    for (int i = 0; i < 5; i++) rb[i] = {$urandom, $urandom};
    ra = {$urandom, $urandom};
    input_b = rb[0];
    input_b_stb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nextSample;
      checkOutput("b_ack_early", 64'(input_b_ack), 64'd0);
      nextDrive;
      input_b = rb[i+1];
    end
    input_a = ra;
    input_a_stb = 1'b1;
    nextSample;
    checkOutput("ord_a_ack", 64'(input_a_ack), 64'd1);
    checkOutput("ord_b_ack_with_a", 64'(input_b_ack), 64'd0);
    nextDrive;
    input_a_stb = 1'b0;
    input_b = rb[4];
    nextSample;
    checkOutput("ord_b_ack_after_a", 64'(input_b_ack), 64'd1);
    nextDrive;
    input_b_stb = 1'b0;
    input_b = ~rb[4];
    nextSample;
    checkOutput("ord_start", 64'(core_start), 64'd1);
    checkOutput("ord_core_a", core_a, ra);
    checkOutput("ord_core_b", core_b, rb[4]);
    output_z_ack = 1'b1;
    waitDrain("ord_drain");
    nextDrive;
    output_z_ack = 1'b0;

    // Saturated streaming with the core finishing in the START cycle
    idle(10);
    core_lat = 0;
    base = done_count;
    input_a = {$urandom, $urandom};
    input_b = {$urandom, $urandom};
    input_a_stb = 1'b1;
    input_b_stb = 1'b1;
    output_z_ack = 1'b1;
    for (int i = 0; i < 40; i++) begin
      nextSample;
      checkOutput("stream_z_stb", 64'(output_z_stb), 64'((i % 4) == 3));
      nextDrive;
      input_a = {$urandom, $urandom};
      input_b = {$urandom, $urandom};
    end
    input_a_stb = 1'b0;
    input_b_stb = 1'b0;
    output_z_ack = 1'b0;
    checkOutput("stream_count", 64'(op_count), 64'(16'(base + 10)));

    // Reset during WAIT; the core's done pulse lands two cycles after reset
    idle(10);
    core_lat = 3;
    applyStimulus({$urandom, $urandom}, {$urandom, $urandom});
    nextSample;
    checkOutput("rw_start", 64'(core_start), 64'd1);
    nextSample;
    checkOutput("rw_wait_no_start", 64'(core_start), 64'd0);
    #1;
    reset_n = 1'b0;
    #1;
    sb.delete();
    done_count = 0;
    checkOutput("rw_core_a_zero", core_a, 64'd0);
    checkOutput("rw_core_b_zero", core_b, 64'd0);
    checkOutput("rw_z_zero", output_z, 64'd0);
    checkOutput("rw_count_zero", 64'(op_count), 64'd0);
    nextDrive;
    reset_n = 1'b1;
    nextSample;
    checkOutput("rw_reset_cycle", 64'(input_a_ack), 64'd0);
    for (int i = 0; i < 3; i++) begin
      nextSample;
      checkOutput("rw_hold_get_a", 64'(input_a_ack), 64'd1);
      checkOutput("rw_no_z_stb", 64'(output_z_stb), 64'd0);
      checkOutput("rw_z_still_zero", output_z, 64'd0);
    end
    core_lat = 2;
    output_z_ack = 1'b1;
    applyStimulus({$urandom, $urandom}, {$urandom, $urandom});
    waitDrain("rw_next_drain");
    nextDrive;
    output_z_ack = 1'b0;
    nextSample;
    checkOutput("rw_final_count", 64'(op_count), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
